// File: rtl/bufferm_rd_arbiter.sv
// Round-robin read arbiter: grants one requester at a time a burst of consecutive
// bufferM reads and returns the words tagged with the owner's id.
//   state | meaning
//   IDLE  | waiting for any req; picks next round-robin winner
//   ISSUE | one read address per cycle, down-counting remaining words
//   DRAIN | last read word returning; then back to IDLE
module bufferm_rd_arbiter #(
    parameter int addrLen = 10,
    parameter int dataLen = 32,
    parameter int NUM_REQ = 4,
    parameter int idLen   = 2,
    parameter int lenLen  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*addrLen-1:0]  req_addr,
    input  logic [NUM_REQ*lenLen-1:0]   req_len,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        busy,
    output logic [addrLen-1:0]          rom_rd_addr,
    input  logic [dataLen-1:0]          rom_data_in,
    output logic                        rsp_valid,
    output logic [idLen-1:0]            rsp_id,
    output logic [dataLen-1:0]          rsp_data,
    output logic                        rsp_last
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [idLen:0] NUM_REQ_W = (idLen+1)'(NUM_REQ);

    state_t               state, state_nxt;
    logic [idLen-1:0]     last_winner, last_winner_nxt, winner;
    logic [idLen:0]       cand;
    logic                 found;
    logic [lenLen-1:0]    cnt, cnt_nxt, len_sel;
    logic [addrLen-1:0]   addr_nxt;
    logic [NUM_REQ-1:0]   gnt_nxt;
    logic                 busy_nxt, rsp_valid_nxt, rsp_last_nxt;
    logic [idLen-1:0]     rsp_id_nxt;

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = last_winner;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_winner} + (idLen+1)'(i);
            if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
            if (!found && req[cand[idLen-1:0]]) begin
                found  = 1'b1;
                winner = cand[idLen-1:0];
            end
        end
    end

    assign len_sel = req_len[int'(winner)*lenLen +: lenLen];

    always_comb begin
        state_nxt       = state;
        last_winner_nxt = last_winner;
        cnt_nxt         = cnt;
        addr_nxt        = '0;
        gnt_nxt         = '0;
        busy_nxt        = 1'b0;
        rsp_valid_nxt   = 1'b0;
        rsp_last_nxt    = 1'b0;
        rsp_id_nxt      = rsp_id;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt       = ISSUE;
                    last_winner_nxt = winner;
                    rsp_id_nxt      = winner;
                    gnt_nxt         = NUM_REQ'(1) << winner;
                    addr_nxt        = req_addr[int'(winner)*addrLen +: addrLen];
                    // cnt holds words remaining after the current one; zero length acts as one
                    cnt_nxt         = (len_sel == '0) ? '0 : len_sel - lenLen'(1);
                    busy_nxt        = 1'b1;
                end
            end
            ISSUE: begin
                busy_nxt      = 1'b1;
                rsp_valid_nxt = 1'b1;
                if (cnt == '0) begin
                    rsp_last_nxt = 1'b1;
                    state_nxt    = DRAIN;
                end else begin
                    cnt_nxt  = cnt - lenLen'(1);
                    addr_nxt = rom_rd_addr + addrLen'(1);
                end
            end
            DRAIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_winner <= idLen'(NUM_REQ - 1);
            cnt         <= '0;
            gnt         <= '0;
            busy        <= 1'b0;
            rom_rd_addr <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_last    <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_winner <= last_winner_nxt;
            cnt         <= cnt_nxt;
            gnt         <= gnt_nxt;
            busy        <= busy_nxt;
            rom_rd_addr <= addr_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_id      <= rsp_id_nxt;
            rsp_last    <= rsp_last_nxt;
        end
    end

    // bufferM output is already registered, so data passes straight through.
    assign rsp_data = rom_data_in;

endmodule

// File: tb/tb_bufferm_rd_arbiter.sv
// Scoreboard bench for bufferm_rd_arbiter: a transaction-level model predicts grants,
// addresses and returned words; a negedge monitor compares them against the DUT.
module tb_bufferm_rd_arbiter;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*LW-1:0] req_len = '0;
    logic [N-1:0]    gnt;
    logic            busy;
    logic [AW-1:0]   rom_rd_addr;
    logic [DW-1:0]   rom_data_in;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            rsp_last;

    logic [N*AW-1:0] stage_addr = '0;
    logic [N*LW-1:0] stage_len = '0;
    logic [DW-1:0]   mem [0:(1<<AW)-1];

    bufferm_rd_arbiter #(.addrLen(AW), .dataLen(DW), .NUM_REQ(N), .idLen(IW), .lenLen(LW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_len(req_len),
        .gnt(gnt), .busy(busy), .rom_rd_addr(rom_rd_addr), .rom_data_in(rom_data_in),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_last(rsp_last)
    );

    always #5 clk = ~clk;

    // bufferM stand-in: registered read, data one cycle after address
    always @(posedge clk) rom_data_in <= mem[rom_rd_addr];

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    typedef struct {int e; int id;} gnt_t;
    typedef struct {int e; int id; logic [DW-1:0] data; bit last;} rsp_t;
    gnt_t gq[$];
    rsp_t rq[$];
    int   exp_addr[int];
    bit   exp_busy[int];
    int   m_lw = N - 1;
    int   m_next = 0;

    // Reference: the value of req present at edge ne decides the next burst.
    task automatic model_step();
        int ne, w, a, len, c;
        ne = edge_cnt + 1;
        if (ne >= m_next && req != '0) begin
            w = -1;
            for (int i = 1; i <= N; i++) begin
                c = (m_lw + i) % N;
                if (w < 0 && req[c]) w = c;
            end
            a   = int'(req_addr[w*AW +: AW]);
            len = int'(req_len[w*LW +: LW]);
            if (len == 0) len = 1;
            gq.push_back('{ne, w});
            for (int k = 0; k < len; k++) begin
                exp_addr[ne + k] = (a + k) % (1 << AW);
                rq.push_back('{ne + 1 + k, w, mem[(a + k) % (1 << AW)], k == len - 1});
            end
            for (int k = 0; k <= len; k++) exp_busy[ne + k] = 1'b1;
            m_lw   = w;
            m_next = ne + len + 2;
        end
    endtask

    task automatic set_fld(input int i, input int a, input int l);
        stage_addr[i*AW +: AW] = AW'(a);
        stage_len[i*LW +: LW]  = LW'(l);
    endtask

    task automatic drive(input logic [N-1:0] r);
        @(negedge clk);
        req      = r;
        req_addr = stage_addr;
        req_len  = stage_len;
        model_step();
    endtask

    task automatic idle(input int n);
        repeat (n) drive('0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        req   = '0;
        gq.delete();
        rq.delete();
        exp_addr.delete();
        exp_busy.delete();
        m_lw   = N - 1;
        m_next = 0;
        #1;
        check("rst_now_gnt", 64'(gnt), 0);
        check("rst_now_busy", 64'(busy), 0);
        check("rst_now_addr", 64'(rom_rd_addr), 0);
        check("rst_now_valid", 64'(rsp_valid), 0);
        check("rst_now_id", 64'(rsp_id), 0);
        check("rst_now_last", 64'(rsp_last), 0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        int   e, ea;
        bit   eb;
        gnt_t g;
        rsp_t r;
        e = edge_cnt;
        if (reset) begin
            check("rst_gnt", 64'(gnt), 0);
            check("rst_valid", 64'(rsp_valid), 0);
            check("rst_addr", 64'(rom_rd_addr), 0);
        end else begin
            if (gnt != '0) begin
                if (gq.size() == 0) check("gnt_unexpected", 64'(gnt), 0);
                else begin
                    g = gq.pop_front();
                    check("gnt_value", 64'(gnt), 64'(1 << g.id));
                    check("gnt_cycle", 64'(e), 64'(g.e));
                end
            end else if (gq.size() > 0 && gq[0].e <= e) begin
                g = gq.pop_front();
                check("gnt_missing", 64'(gnt), 64'(1 << g.id));
            end
            if (rsp_valid) begin
                if (rq.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 0);
                else begin
                    r = rq.pop_front();
                    check("rsp_cycle", 64'(e), 64'(r.e));
                    check("rsp_id", 64'(rsp_id), 64'(r.id));
                    check("rsp_data", 64'(rsp_data), 64'(r.data));
                    check("rsp_last", 64'(rsp_last), 64'(r.last));
                end
            end else begin
                check("rsp_last_idle", 64'(rsp_last), 0);
                if (rq.size() > 0 && rq[0].e <= e) begin
                    r = rq.pop_front();
                    check("rsp_missing", 64'(rsp_valid), 1);
                end
            end
            ea = exp_addr.exists(e) ? exp_addr[e] : 0;
            if (exp_addr.exists(e)) exp_addr.delete(e);
            check("rom_rd_addr", 64'(rom_rd_addr), 64'(ea));
            eb = exp_busy.exists(e);
            if (eb) exp_busy.delete(e);
            check("busy", 64'(busy), 64'(eb));
        end
    end

    initial begin
        logic [N-1:0] r;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[0] = 32'd1;
        mem[1] = 32'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;

        // single requester 2, addr 5, len 3
        set_fld(2, 5, 3);
        drive(4'b0100);
        idle(8);

        // all four held, len 1: fair rotation from requester 0
        do_reset();
        for (int i = 0; i < N; i++) set_fld(i, i * 16, 1);
        repeat (15) drive(4'b1111);
        idle(4);

        // address wrap at the top of bufferM
        set_fld(1, 1023, 3);
        drive(4'b0010);
        idle(6);

        // zero length behaves as a single word
        set_fld(3, 100, 0);
        drive(4'b1000);
        idle(4);

        // words 1 then 0 from the start of bufferM
        set_fld(0, 0, 2);
        drive(4'b0001);
        idle(5);

        // reset in the middle of a long burst
        set_fld(1, 200, 8);
        drive(4'b0010);
        idle(3);
        do_reset();
        idle(12);

        // randomized traffic, including req changes while busy
        r = '0;
        repeat (800) begin
            if ($urandom_range(0, 3) == 0) begin
                r = N'($urandom);
                for (int i = 0; i < N; i++)
                    set_fld(i, int'($urandom_range(0, 1023)),
                            ($urandom_range(0, 15) == 0) ? int'($urandom_range(7, 40))
                                                         : int'($urandom_range(0, 6)));
            end
            drive(r);
        end
        idle(50);
        check("sb_gnt_left", 64'(gq.size()), 0);
        check("sb_rsp_left", 64'(rq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
